// File: rtl/layer_0_maxpool2x2.sv
// 2x2 stride-2 max-pool over a raster-order IEEE-754 single stream, one pooled pixel per odd-row/odd-col input.
// Optional frame markers sof_out/eof_out are compiled in with MAXPOOL_FRAME_FLAGS_EN.
module layer_0_maxpool2x2 #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 416
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out
`ifdef MAXPOOL_FRAME_FLAGS_EN
    ,
    output logic                  sof_out,
    output logic                  eof_out
`endif
);

    localparam int CW   = ($clog2(IMG_SIZE) < 2) ? 2 : $clog2(IMG_SIZE);
    localparam int HALF = IMG_SIZE / 2;
    localparam logic [CW-1:0] POS_LAST = CW'(IMG_SIZE - 1);
    localparam logic [CW-1:0] POS_ONE  = CW'(1);

    // Bit-pattern ordering of IEEE-754 words; -0 loses to +0 because its pattern is treated as negative.
    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH-1:0] r;
        if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
            r = a[DATA_WIDTH-1] ? b : a;
        end else if (a[DATA_WIDTH-1] == 1'b0) begin
            r = (a[DATA_WIDTH-2:0] >= b[DATA_WIDTH-2:0]) ? a : b;
        end else begin
            r = (a[DATA_WIDTH-2:0] <= b[DATA_WIDTH-2:0]) ? a : b;
        end
        return r;
    endfunction

    logic [CW-1:0]         col_r;
    logic [CW-1:0]         row_r;
    logic [DATA_WIDTH-1:0] h_left_r;
    logic [DATA_WIDTH-1:0] lb_rd_r;
    logic [DATA_WIDTH-1:0] line_buf_r [HALF];
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  valid_out_r;
    logic [DATA_WIDTH-1:0] hmax_s;
    logic [DATA_WIDTH-1:0] vmax_s;
    logic [CW-2:0]         lb_idx_s;
    logic                  col_last_s;
    logic                  row_last_s;
    logic                  first_win_s;

    // Horizontal and vertical window maxima plus position decodes.
    always_comb begin
        hmax_s      = fmax(h_left_r, data_in);
        vmax_s      = fmax(lb_rd_r, hmax_s);
        lb_idx_s    = col_r[CW-1:1];
        col_last_s  = (col_r == POS_LAST);
        row_last_s  = (row_r == POS_LAST);
        first_win_s = (col_r == POS_ONE) && (row_r == POS_ONE);
    end

    // Line buffer: top-row pair maxima written on even rows, prefetched on the even column of odd rows.
    always_ff @(posedge Clk) begin
        if (valid_in && !Rst) begin
            if (row_r[0] == 1'b0 && col_r[0] == 1'b1) begin
                line_buf_r[lb_idx_s] <= hmax_s;
            end else if (row_r[0] == 1'b1 && col_r[0] == 1'b0) begin
                lb_rd_r <= line_buf_r[lb_idx_s];
            end else begin
                lb_rd_r <= lb_rd_r;
            end
        end else begin
            lb_rd_r <= lb_rd_r;
        end
    end

    // Raster position counters, left-pixel hold and registered pooled output.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            col_r       <= {CW{1'b0}};
            row_r       <= {CW{1'b0}};
            h_left_r    <= {DATA_WIDTH{1'b0}};
            data_out_r  <= {DATA_WIDTH{1'b0}};
            valid_out_r <= 1'b0;
`ifdef MAXPOOL_FRAME_FLAGS_EN
            sof_out     <= 1'b0;
            eof_out     <= 1'b0;
`endif
        end else begin
            valid_out_r <= 1'b0;
`ifdef MAXPOOL_FRAME_FLAGS_EN
            sof_out     <= 1'b0;
            eof_out     <= 1'b0;
`endif
            if (valid_in) begin
                if (col_last_s) begin
                    col_r <= {CW{1'b0}};
                    row_r <= row_last_s ? {CW{1'b0}} : row_r + POS_ONE;
                end else begin
                    col_r <= col_r + POS_ONE;
                end
                if (col_r[0] == 1'b0) begin
                    h_left_r <= data_in;
                end else if (row_r[0] == 1'b1) begin
                    data_out_r  <= vmax_s;
                    valid_out_r <= 1'b1;
`ifdef MAXPOOL_FRAME_FLAGS_EN
                    sof_out     <= first_win_s;
                    eof_out     <= col_last_s && row_last_s;
`endif
                end else begin
                    h_left_r <= h_left_r;
                end
            end else begin
                col_r <= col_r;
            end
        end
    end

    assign data_out  = data_out_r;
    assign valid_out = valid_out_r;

endmodule

// File: tb/tb_layer_0_maxpool2x2.sv
// Self-checking bench: a 4x4 instance for value/latency/reset checks and a 16x16 instance for pulse counts.
module tb_layer_0_maxpool2x2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_a, d_b;
    logic        v_a, v_b;
    logic [31:0] q_a, q_b;
    logic        vo_a, vo_b;
`ifdef MAXPOOL_FRAME_FLAGS_EN
    logic        sof_a, eof_a, sof_b, eof_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layer_0_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(4)) u_small (
        .Clk(clk), .Rst(rst), .data_in(d_a), .valid_in(v_a),
        .data_out(q_a), .valid_out(vo_a)
`ifdef MAXPOOL_FRAME_FLAGS_EN
        , .sof_out(sof_a), .eof_out(eof_a)
`endif
    );

    layer_0_maxpool2x2 #(.DATA_WIDTH(32), .IMG_SIZE(16)) u_big (
        .Clk(clk), .Rst(rst), .data_in(d_b), .valid_in(v_b),
        .data_out(q_b), .valid_out(vo_b)
`ifdef MAXPOOL_FRAME_FLAGS_EN
        , .sof_out(sof_b), .eof_out(eof_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Ordering key: a real number line with -0 placed just below +0.
    function automatic longint fkey(input logic [31:0] a);
        if (a[31]) return -longint'(a[30:0]) - 64'sd1;
        else return longint'(a[30:0]);
    endfunction

    function automatic logic [31:0] max4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        logic [31:0] w [4];
        logic [31:0] best;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        best = w[0];
        for (int i = 1; i < 4; i++) if (fkey(w[i]) > fkey(best)) best = w[i];
        return best;
    endfunction

    logic [31:0] frame_a [16];
    int          k_a = 0;
    int          outs_a = 0;
    logic [31:0] got_q [$];

    // Send one pixel to the 4x4 instance and check the cycle right after it against the model.
    task automatic push_a(input logic [31:0] d);
        int r, c, idx;
        bit exp_v;
        logic [31:0] exp_d;
        idx = k_a % 16;
        r = idx / 4;
        c = idx % 4;
        frame_a[idx] = d;
        exp_v = (r % 2 == 1) && (c % 2 == 1);
        exp_d = 32'h0;
        if (exp_v) exp_d = max4(frame_a[idx-5], frame_a[idx-4], frame_a[idx-1], frame_a[idx]);
        d_a = d;
        v_a = 1'b1;
        @(posedge clk);
        #1;
        v_a = 1'b0;
        check("valid_a", {31'b0, vo_a}, {31'b0, exp_v});
        if (exp_v) begin
            check("data_a", q_a, exp_d);
            got_q.push_back(q_a);
            outs_a++;
        end
`ifdef MAXPOOL_FRAME_FLAGS_EN
        check("sof_a", {31'b0, sof_a}, {31'b0, exp_v && r == 1 && c == 1});
        check("eof_a", {31'b0, eof_a}, {31'b0, exp_v && r == 3 && c == 3});
`endif
        k_a++;
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle_valid_a", {31'b0, vo_a}, 32'h0);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) == 0) w = {w[31], 31'h0};
        return w;
    endfunction

    logic [31:0] dir_frame [16];
    logic [31:0] dir_exp   [4];
    int          row_cnt [16];
    int          pulses, sof_cnt, eof_cnt;

    initial begin
        dir_frame[0]  = 32'h3f800000; dir_frame[1]  = 32'h40000000;
        dir_frame[2]  = 32'hbf800000; dir_frame[3]  = 32'hc0000000;
        dir_frame[4]  = 32'h3f000000; dir_frame[5]  = 32'hbf800000;
        dir_frame[6]  = 32'hc0400000; dir_frame[7]  = 32'hbf000000;
        dir_frame[8]  = 32'h80000000; dir_frame[9]  = 32'h80000000;
        dir_frame[10] = 32'hc0000000; dir_frame[11] = 32'hbf800000;
        dir_frame[12] = 32'h00000000; dir_frame[13] = 32'h80000000;
        dir_frame[14] = 32'h3f000000; dir_frame[15] = 32'hbf000000;
        dir_exp[0] = 32'h40000000; dir_exp[1] = 32'hbf000000;
        dir_exp[2] = 32'h00000000; dir_exp[3] = 32'h3f000000;

        rst = 1'b1; v_a = 1'b0; v_b = 1'b0; d_a = 32'h0; d_b = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_data_a", q_a, 32'h0);
        check("reset_valid_a", {31'b0, vo_a}, 32'h0);
        check("reset_data_b", q_b, 32'h0);
        check("reset_valid_b", {31'b0, vo_b}, 32'h0);

        // Directed windows, no gaps.
        for (int i = 0; i < 16; i++) push_a(dir_frame[i]);
        check("dir_count", got_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) check("dir_value", (got_q.size() > i) ? got_q[i] : 32'hdeadbeef, dir_exp[i]);
        idle_a(2);

        // Random frames with random idle gaps.
        for (int f = 0; f < 3; f++) begin
            outs_a = 0;
            for (int i = 0; i < 16; i++) begin
                push_a(rand_word());
                idle_a($urandom_range(0, 5));
            end
            check("rand_count", outs_a, 32'd4);
        end

        // Reset mid-frame; valid_in during reset must be ignored.
        for (int i = 0; i < 6; i++) push_a(rand_word());
        rst = 1'b1; v_a = 1'b1; d_a = 32'h7f7fffff;
        @(posedge clk);
        #1;
        rst = 1'b0; v_a = 1'b0;
        check("midrst_data", q_a, 32'h0);
        check("midrst_valid", {31'b0, vo_a}, 32'h0);
        k_a = 0;
        idle_a(3);
        outs_a = 0;
        for (int i = 0; i < 16; i++) push_a(rand_word());
        check("post_rst_count", outs_a, 32'd4);

        // 16x16 instance: two back-to-back frames, count pulses per frame and per row.
        for (int f = 0; f < 2; f++) begin
            pulses = 0; sof_cnt = 0; eof_cnt = 0;
            for (int r = 0; r < 16; r++) row_cnt[r] = 0;
            for (int k = 0; k < 256; k++) begin
                d_b = $urandom;
                v_b = 1'b1;
                @(posedge clk);
                #1;
                if (vo_b) begin
                    pulses++;
                    row_cnt[k / 16]++;
`ifdef MAXPOOL_FRAME_FLAGS_EN
                    if (sof_b) begin
                        sof_cnt++;
                        check("sof_first", pulses, 32'd1);
                    end
                    if (eof_b) begin
                        eof_cnt++;
                        check("eof_last", pulses, 32'd64);
                    end
`endif
                end
            end
            check("frame_pulses", pulses, 32'd64);
            for (int r = 0; r < 16; r++) check("row_pulses", row_cnt[r], (r % 2 == 1) ? 32'd8 : 32'd0);
`ifdef MAXPOOL_FRAME_FLAGS_EN
            check("sof_count", sof_cnt, 32'd1);
            check("eof_count", eof_cnt, 32'd1);
`endif
        end
        v_b = 1'b0;
        @(posedge clk);
        #1;
        check("big_idle_valid", {31'b0, vo_b}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
